// File: rtl/channel_rr_merge.sv
// N-way round-robin merge of valid/acknowledge channels into one tagged output FIFO.
// Each accepted word carries its source index in the MSBs; in_a is combinational, out_* are flop-driven.
module channel_rr_merge #(
  parameter int unsigned N     = 8,
  parameter int unsigned NumIn = 4,
  parameter int unsigned Depth = 4,
  parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumIn*N-1:0]        in_d,
  input  logic [NumIn-1:0]          in_v,
  output logic [NumIn-1:0]          in_a,
  output logic [IdxW+N-1:0]         out_d,
  output logic                      out_v,
  input  logic                      out_a,
  output logic [$clog2(Depth):0]    count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = IdxW + N;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   mem_q [Depth];

  logic            grant_v;
  logic [IdxW-1:0] grant_idx;
  logic            full;
  logic            push;
  logic            pop;

  // Reduce an index in [0, 2*NumIn) back into [0, NumIn).
  function automatic logic [IdxW-1:0] wrap_idx(input int unsigned v);
    return IdxW'((v >= NumIn) ? (v - NumIn) : v);
  endfunction

  // First valid channel at or after ptr, wrapping.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int unsigned off = 0; off < NumIn; off++) begin
      if (!grant_v && in_v[wrap_idx(32'(ptr_q) + off)]) begin
        grant_v   = 1'b1;
        grant_idx = wrap_idx(32'(ptr_q) + off);
      end
    end
  end

  // Backpressure uses only the registered count, never out_a.
  assign full = (count_q == CW'(Depth));
  assign push = grant_v & ~full & ~reset;
  assign pop  = (count_q != '0) & out_a;

  always_comb begin
    in_a = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      in_a[i] = push && (grant_idx == IdxW'(i));
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q;
    if (push) begin
      ptr_d = wrap_idx(32'(grant_idx) + 1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= {grant_idx, in_d[32'(grant_idx)*N +: N]};
    end
  end

  assign out_d = mem_q[head_q];
  assign out_v = (count_q != '0);
  assign count = count_q;

endmodule
